// File: rtl/cpu_sim_axi3_master_if.sv
// axi3_interface: AXI3 signal bundle with master and slave views
interface axi3_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 12
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [1:0]              arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cpu_sim_axi3_master.sv
// cpu_sim_axi3_master: single-outstanding AXI3 master; cmd_* valid/ready in, rsp_* pulse out, axi3 master port
module cpu_sim_axi3_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 12,
  parameter int TXN_ID     = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axi3_interface.master         axi3
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, tmo_q, tmo_d;
  logic [1:0] resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic busy, timeout_hit;
  logic unused_ok;
  assign busy = state_q != IDLE && state_q != DONE;
  assign timeout_hit = TIMEOUT != 0 && busy && cnt_q >= 32'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d = bready_q;
    rready_d = rready_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    tmo_d = tmo_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = busy ? cnt_q + 32'd1 : cnt_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
        wdata_d = cmd_wdata;
        cnt_d = 32'd1;
        rdata_d = '0;
        resp_d = 2'b00;
        tmo_d = 1'b0;
        state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
        awvalid_d = cmd_write;
        wvalid_d = cmd_write;
        arvalid_d = !cmd_write;
      end
      WR_ADDR_DATA: begin
        awvalid_d = awvalid_q && !axi3.awready;
        wvalid_d = wvalid_q && !axi3.wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (axi3.bvalid) begin
        resp_d = axi3.bresp;
        bready_d = 1'b0;
        state_d = DONE;
      end
      RD_ADDR: if (axi3.arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (axi3.rvalid) begin
        rdata_d = axi3.rdata;
        resp_d = axi3.rresp;
        rready_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      {awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d} = '0;
      resp_d = 2'b10;
      tmo_d = 1'b1;
      state_d = DONE;
    end
    cmd_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == DONE;
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
      {awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q} <= '0;
      {cmd_ready_q, rsp_valid_q, tmo_q} <= '0;
      resp_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      {awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q} <= {awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d};
      {cmd_ready_q, rsp_valid_q, tmo_q} <= {cmd_ready_d, rsp_valid_d, tmo_d};
      resp_q <= resp_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign rsp_timeout = tmo_q;
  assign axi3.awid = ID_WIDTH'(TXN_ID);
  assign axi3.awaddr = addr_q;
  assign axi3.awlen = 4'd0;
  assign axi3.awsize = 3'b010;
  assign axi3.awburst = 2'b01;
  assign axi3.awlock = 2'b00;
  assign axi3.awcache = 4'd0;
  assign axi3.awprot = 3'd0;
  assign axi3.awqos = 4'd0;
  assign axi3.awvalid = awvalid_q;
  assign axi3.wid = ID_WIDTH'(TXN_ID);
  assign axi3.wdata = wdata_q;
  assign axi3.wstrb = '1;
  assign axi3.wlast = 1'b1;
  assign axi3.wvalid = wvalid_q;
  assign axi3.bready = bready_q;
  assign axi3.arid = ID_WIDTH'(TXN_ID);
  assign axi3.araddr = addr_q;
  assign axi3.arlen = 4'd0;
  assign axi3.arsize = 3'b010;
  assign axi3.arburst = 2'b01;
  assign axi3.arlock = 2'b00;
  assign axi3.arcache = 4'd0;
  assign axi3.arprot = 3'd0;
  assign axi3.arqos = 4'd0;
  assign axi3.arvalid = arvalid_q;
  assign axi3.rready = rready_q;
  assign unused_ok = ^{axi3.bid, axi3.rid, axi3.rlast, cmd_addr[1:0]};
endmodule

// File: tb/tb_cpu_sim_axi3_master.sv
// tb_cpu_sim_axi3_master: scoreboard bench with a behavioural AXI3 slave
module tb_cpu_sim_axi3_master;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  axi3_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(12)) ax ();
  cpu_sim_axi3_master #(.TIMEOUT(16)) dut (
    .aclk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .axi3(ax)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] rdata; logic [1:0] resp; logic tmo; int lat; int acc;} exp_t;
  exp_t sb[$];
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  int total = 0, bad = 0, cyc = 0, rsp_cnt = 0;
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic b_block = 0;
  logic [1:0] bresp_k = 0, rresp_k = 0;
  logic [31:0] rdata_k = 0;
  int aw_tot = 0, w_tot = 0, ar_tot = 0, b_tot = 0, r_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  initial forever @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic chk_next;
    exp_t e;
    chk_next = 0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("cmd_ready_after_rsp", cmd_ready, 1);
        chk("arvalid_after_rsp", ax.arvalid, 0);
        chk_next = 0;
      end
      if (rsp_valid) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
          chk("rsp_timeout", rsp_timeout, e.tmo);
          chk("latency", cyc - e.acc + 2, e.lat);
        end
        chk("cmd_ready_during_rsp", cmd_ready, 0);
        if (rsp_timeout) chk("valids_after_tmo", {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready}, 0);
        chk_next = 1;
        rsp_cnt++;
      end
    end
  end
  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, p_rst;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [8:0] p_awattr, p_arattr;
    logic [4:0] p_wattr;
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, p_rst} = '0;
    {p_awaddr, p_wdata, p_araddr, p_awattr, p_arattr, p_wattr} = '0;
    {aw_cnt, w_cnt, ar_cnt, r_cnt} = '0;
    {ax.awready, ax.wready, ax.arready, ax.bvalid, ax.rvalid} = '0;
    ax.bresp = 0; ax.rresp = 0; ax.rdata = 0; ax.bid = 0; ax.rid = 0; ax.rlast = 1;
    forever begin
      @(negedge clk);
      if (p_awv && p_awr) begin
        aw_tot++;
        chk("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) chk("awaddr", p_awaddr, exp_aw.pop_front());
        chk("aw_len_size_burst", p_awattr, {4'd0, 3'b010, 2'b01});
        chk("awvalid_drop", ax.awvalid, 0);
      end else if (p_awv && !p_rst && !(rsp_valid && rsp_timeout)) begin
        chk("awvalid_hold", ax.awvalid, 1);
        chk("awaddr_stable", ax.awaddr, p_awaddr);
      end
      if (p_wv && p_wr) begin
        w_tot++;
        chk("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) chk("wdata", p_wdata, exp_w.pop_front());
        chk("wstrb_wlast", p_wattr, {4'hF, 1'b1});
        chk("wvalid_drop", ax.wvalid, 0);
      end else if (p_wv && !p_rst && !(rsp_valid && rsp_timeout)) begin
        chk("wvalid_hold", ax.wvalid, 1);
        chk("wdata_stable", ax.wdata, p_wdata);
      end
      if (p_arv && p_arr) begin
        ar_tot++;
        chk("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) chk("araddr", p_araddr, exp_ar.pop_front());
        chk("ar_len_size_burst", p_arattr, {4'd0, 3'b010, 2'b01});
        chk("arvalid_drop", ax.arvalid, 0);
      end else if (p_arv && !p_rst && !(rsp_valid && rsp_timeout)) begin
        chk("arvalid_hold", ax.arvalid, 1);
        chk("araddr_stable", ax.araddr, p_araddr);
      end
      if (p_bv && p_br) begin
        b_tot++;
        ax.bvalid = 0;
      end
      if (p_rv && p_rr) begin
        r_tot++;
        ax.rvalid = 0;
        r_cnt = 0;
      end
      ax.awready = ax.awvalid && aw_cnt == aw_delay;
      aw_cnt = ax.awvalid ? aw_cnt + 1 : 0;
      ax.wready = ax.wvalid && w_cnt == w_delay;
      w_cnt = ax.wvalid ? w_cnt + 1 : 0;
      ax.arready = ax.arvalid && ar_cnt == ar_delay;
      ar_cnt = ax.arvalid ? ar_cnt + 1 : 0;
      ax.bvalid = ax.bvalid || (aw_tot > b_tot && w_tot > b_tot && !b_block);
      ax.bresp = bresp_k;
      if (ar_tot > r_tot && !ax.rvalid) begin
        ax.rvalid = r_cnt == r_delay;
        r_cnt++;
      end
      ax.rdata = rdata_k;
      ax.rresp = rresp_k;
      p_awv = ax.awvalid; p_awr = ax.awready; p_awaddr = ax.awaddr;
      p_awattr = {ax.awlen, ax.awsize, ax.awburst};
      p_wv = ax.wvalid; p_wr = ax.wready; p_wdata = ax.wdata;
      p_wattr = {ax.wstrb, ax.wlast};
      p_arv = ax.arvalid; p_arr = ax.arready; p_araddr = ax.araddr;
      p_arattr = {ax.arlen, ax.arsize, ax.arburst};
      p_bv = ax.bvalid; p_br = ax.bready;
      p_rv = ax.rvalid; p_rr = ax.rready;
      p_rst = reset;
    end
  end
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic [1:0] eresp, input logic etmo,
                        input int elat, input int linger);
    exp_t e;
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    if (!etmo && w) begin
      exp_aw.push_back(a & 32'hFFFF_FFFC);
      exp_w.push_back(d);
    end else if (!etmo) exp_ar.push_back(a & 32'hFFFF_FFFC);
    @(negedge clk);
    chk("accepted", cmd_ready, 0);
    e = '{er, eresp, etmo, elat, cyc};
    sb.push_back(e);
    cmd_addr = 32'h0000_FFF0; cmd_wdata = ~d; cmd_write = ~w;
    repeat (linger) @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 0);
    chk("rst_axi", {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready}, 0);
    reset = 0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);
    do_cmd(1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2'b00, 0, 4, 2);
    ar_delay = 2; r_delay = 3; rdata_k = 32'h1234_5678;
    do_cmd(0, 32'h0000_0104, 32'h0, 32'h1234_5678, 2'b00, 0, 9, 0);
    ar_delay = 0; r_delay = 0; rdata_k = 32'hCAFE_F00D;
    do_cmd(0, 32'h0000_0108, 32'h0, 32'hCAFE_F00D, 2'b00, 0, 4, 0);
    aw_delay = 5; w_delay = 0;
    do_cmd(1, 32'h0000_0203, 32'hA5A5_0001, 32'h0, 2'b00, 0, 9, 0);
    aw_delay = 0; w_delay = 5;
    do_cmd(1, 32'h0000_0208, 32'h0F0F_1234, 32'h0, 2'b00, 0, 9, 0);
    w_delay = 0; bresp_k = 2'b10;
    do_cmd(1, 32'h0000_010C, 32'h55AA_55AA, 32'h0, 2'b10, 0, 4, 0);
    bresp_k = 2'b00; rresp_k = 2'b11; rdata_k = 32'h0BAD_F00D;
    do_cmd(0, 32'h0000_0110, 32'h0, 32'h0BAD_F00D, 2'b11, 0, 4, 0);
    rresp_k = 2'b00; ar_delay = 1000;
    do_cmd(0, 32'h0000_0300, 32'h0, 32'h0, 2'b10, 1, 17, 0);
    ar_delay = 0; b_block = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0400; cmd_wdata = 32'h7777_0000;
    exp_aw.push_back(32'h0000_0400);
    exp_w.push_back(32'h7777_0000);
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!ax.bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bready_reached", ax.bready, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_bready", ax.bready, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    reset = 0;
    @(negedge clk);
    chk("cmd_ready_after_mid_rst", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("rsp_count", rsp_cnt, 8);
    chk("b_handshakes", b_tot, 4);
    chk("r_handshakes", r_tot, 3);
    chk("aw_handshakes", aw_tot, 5);
    chk("exp_queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
